conv_arbiter: RTL

CONV_ARBITER -- requirements
Module: conv_arbiter

---
 rtl/conv_arbiter_pkg.sv | 28 ++
 rtl/int_convert.sv | 45 ++++
 rtl/conv_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/conv_arbiter_pkg.sv
// conv_arbiter_pkg: shared widths, conversion-mode encoding and state types
// for the two-requester conversion arbiter.
`default_nettype none

package conv_arbiter_pkg;

    localparam int IN_W_DEF    = 8;
    localparam int EXT_W_DEF   = 16;
    localparam int TRUNC_W_DEF = 4;

    typedef enum logic {
        EXTEND = 1'b0,
        TRUNC  = 1'b1
    } conv_mode_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    typedef enum logic {
        PTR_A = 1'b0,
        PTR_B = 1'b1
    } rr_ptr_e;

endpackage : conv_arbiter_pkg

`default_nettype wire

// File: rtl/int_convert.sv
// int_convert: combinational operand converter, sign-extends IN_W to EXT_W
// or keeps only the low TRUNC_W bits with the rest zeroed.
`default_nettype none

module int_convert
    import conv_arbiter_pkg::*;
#(
    parameter int IN_W    = IN_W_DEF,
    parameter int EXT_W   = EXT_W_DEF,
    parameter int TRUNC_W = TRUNC_W_DEF
) (
    input  logic [IN_W-1:0]  operand,
    input  conv_mode_e       mode,
    output logic [EXT_W-1:0] result
);

    logic [EXT_W-1:0] extended;
    logic [EXT_W-1:0] truncated;

    // Bit-by-bit construction keeps every width combination legal,
    // including EXT_W == IN_W where a replication count would be zero.
    for (genvar g = 0; g < EXT_W; g++) begin : g_bits
        if (g < IN_W) begin : g_ext_low
            assign extended[g] = operand[g];
        end else begin : g_ext_high
            assign extended[g] = operand[IN_W-1];
        end

        if (g < TRUNC_W) begin : g_trunc_low
            assign truncated[g] = operand[g];
        end else begin : g_trunc_high
            assign truncated[g] = 1'b0;
        end
    end

    always_comb begin
        result = extended;
        if (mode == TRUNC) begin
            result = truncated;
        end
    end

endmodule : int_convert

`default_nettype wire

// File: rtl/conv_arbiter.sv
// conv_arbiter: round-robin arbitration of two requesters onto one shared
// converter, with a one-entry result register and saturating grant counters.
`default_nettype none

module conv_arbiter
    import conv_arbiter_pkg::*;
#(
    parameter int IN_W    = IN_W_DEF,
    parameter int EXT_W   = EXT_W_DEF,
    parameter int TRUNC_W = TRUNC_W_DEF
) (
    input  logic             _i_clk,
    input  logic             _i_rst_n,
    input  logic             _i_a_valid,
    input  logic             _i_b_valid,
    input  logic [IN_W-1:0]  _i_a_data,
    input  logic [IN_W-1:0]  _i_b_data,
    input  logic             _i_a_trunc,
    input  logic             _i_b_trunc,
    output logic             a_ready,
    output logic             b_ready,
    output logic             out_valid,
    output logic [EXT_W-1:0] out_data,
    output logic             out_id,
    input  logic             _i_out_ready,
    output logic [7:0]       grant_cnt_a,
    output logic [7:0]       grant_cnt_b
);

    out_state_e       state;
    out_state_e       state_next;
    rr_ptr_e          ptr;
    logic             slot_free;
    logic             grant_a;
    logic             grant_b;
    logic             grant_any;
    logic [IN_W-1:0]  conv_operand;
    conv_mode_e       conv_mode;
    logic [EXT_W-1:0] conv_result;

    assign slot_free = (state == EMPTY) || _i_out_ready;

    // Grants use only valids, the slot status and the pointer, never data.
    // The reset term keeps both readys low while reset is held.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (_i_rst_n && slot_free) begin
            if (_i_a_valid && _i_b_valid) begin
                grant_a = (ptr == PTR_A);
                grant_b = (ptr == PTR_B);
            end else begin
                grant_a = _i_a_valid;
                grant_b = _i_b_valid;
            end
        end
    end

    assign grant_any = grant_a || grant_b;
    assign a_ready   = grant_a;
    assign b_ready   = grant_b;

    // Shared converter input follows whichever side is granted.
    always_comb begin
        conv_operand = _i_a_data;
        conv_mode    = conv_mode_e'(_i_a_trunc);
        if (grant_b) begin
            conv_operand = _i_b_data;
            conv_mode    = conv_mode_e'(_i_b_trunc);
        end
    end

    int_convert #(
        .IN_W    (IN_W),
        .EXT_W   (EXT_W),
        .TRUNC_W (TRUNC_W)
    ) u_int_convert (
        .operand (conv_operand),
        .mode    (conv_mode),
        .result  (conv_result)
    );

    always_ff @(posedge _i_clk or negedge _i_rst_n) begin
        if (!_i_rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (grant_any) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (_i_out_ready && !grant_any) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    assign out_valid = (state == FULL);

    // The result register only loads on a grant, so a stalled result holds.
    always_ff @(posedge _i_clk or negedge _i_rst_n) begin
        if (!_i_rst_n) begin
            out_data <= '0;
            out_id   <= 1'b0;
            ptr      <= PTR_A;
        end else if (grant_any) begin
            out_data <= conv_result;
            out_id   <= grant_b;
            ptr      <= grant_a ? PTR_B : PTR_A;
        end
    end

    always_ff @(posedge _i_clk or negedge _i_rst_n) begin
        if (!_i_rst_n) begin
            grant_cnt_a <= 8'h00;
            grant_cnt_b <= 8'h00;
        end else begin
            if (grant_a && (grant_cnt_a != 8'hFF)) begin
                grant_cnt_a <= grant_cnt_a + 8'd1;
            end
            if (grant_b && (grant_cnt_b != 8'hFF)) begin
                grant_cnt_b <= grant_cnt_b + 8'd1;
            end
        end
    end

endmodule : conv_arbiter

`default_nettype wire
